// File: rtl/axil_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// axil_reg_arbiter_if
// AXI4-Lite bus between the two-requester arbiter (master) and the
// register bank slave.
//   AW channel : AWADDR, AWPROT, AWVALID -> / <- AWREADY
//   W  channel : WDATA, WSTRB, WVALID    -> / <- WREADY
//   B  channel : <- BRESP, BVALID        / BREADY ->
//   AR channel : ARADDR, ARPROT, ARVALID -> / <- ARREADY
//   R  channel : <- RDATA, RRESP, RVALID / RREADY ->
// ---------------------------------------------------------------------------
interface axil_reg_arbiter_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_reg_arbiter.sv
// ---------------------------------------------------------------------------
// axil_reg_arbiter
// Round-robin arbiter/sequencer for two single-word requesters sharing one
// AXI4-Lite register bank. One AXI transaction is in flight at a time.
//   ACLK, ARESET        : clock, async active-high reset
//   REQ_VALID/WE/ADDR/WDATA : per-requester request (requester i in slice i)
//   REQ_READY           : one-cycle acceptance pulse to the granted requester
//   RSP_VALID/RDATA/ERR : one-cycle completion pulse to the owning requester
//   BUSY                : a request is being serviced
//   M_AXI               : AXI4-Lite master port
// ---------------------------------------------------------------------------
module axil_reg_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [1:0]          REQ_VALID,
    input  logic [1:0]          REQ_WE,
    input  logic [2*ADDR_W-1:0] REQ_ADDR,
    input  logic [63:0]         REQ_WDATA,
    output logic [1:0]          REQ_READY,
    output logic [1:0]          RSP_VALID,
    output logic [31:0]         RSP_RDATA,
    output logic                RSP_ERR,
    output logic                BUSY,
    axil_reg_arbiter_if.master  M_AXI
);
    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_DATA, ERR} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);

    state_t            state_q, state_d;
    logic              last_q, last_d;      // requester granted most recently
    logic              gnt_q, gnt_d;        // owner of the in-flight request
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              gnt, accept, g_we, addr_bad;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0]       g_wdata;
    logic              unused_resp_lsb;

    // Grant selection. Acceptance is held off while a response pulse is
    // out so REQ_READY and RSP_VALID never share a cycle.
    always_comb begin
        gnt      = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];
        accept   = (state_q == IDLE) && (rsp_valid_q == 2'b00) && (REQ_VALID != 2'b00);
        g_we     = gnt ? REQ_WE[1] : REQ_WE[0];
        g_addr   = gnt ? REQ_ADDR[ADDR_W +: ADDR_W] : REQ_ADDR[0 +: ADDR_W];
        g_wdata  = gnt ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
        addr_bad = (g_addr[1:0] != 2'b00) || (32'(g_addr) >= ADDR_LIMIT);
        REQ_READY = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                gnt_d   = gnt;
                last_d  = gnt;
                addr_d  = g_addr;
                wdata_d = g_wdata;
                if (addr_bad) begin
                    // Response pulse is live during the single ERR cycle.
                    state_d     = ERR;
                    rsp_valid_d = gnt ? 2'b10 : 2'b01;
                    rsp_err_d   = 1'b1;
                end else if (g_we) begin
                    state_d   = WRITE;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    state_d   = READ;
                    arvalid_d = 1'b1;
                end
            end
            ERR: state_d = IDLE;
            WRITE: begin
                // AW and W retire independently, in either order.
                awvalid_d = awvalid_q & ~M_AXI.AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI.WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: if (M_AXI.BVALID) begin
                bready_d    = 1'b0;
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                rsp_err_d   = M_AXI.BRESP[1];
                state_d     = IDLE;
            end
            READ: if (M_AXI.ARREADY) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RD_DATA;
            end
            RD_DATA: if (M_AXI.RVALID) begin
                rready_d    = 1'b0;
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                rsp_rdata_d = M_AXI.RDATA;
                rsp_err_d   = M_AXI.RRESP[1];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign M_AXI.AWADDR  = addr_q;
    assign M_AXI.AWPROT  = 3'b000;
    assign M_AXI.AWVALID = awvalid_q;
    assign M_AXI.WDATA   = wdata_q;
    assign M_AXI.WSTRB   = 4'hF;
    assign M_AXI.WVALID  = wvalid_q;
    assign M_AXI.BREADY  = bready_q;
    assign M_AXI.ARADDR  = addr_q;
    assign M_AXI.ARPROT  = 3'b000;
    assign M_AXI.ARVALID = arvalid_q;
    assign M_AXI.RREADY  = rready_q;

    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = (state_q != IDLE);

    // Only bit 1 of the response codes distinguishes OKAY from error.
    assign unused_resp_lsb = M_AXI.BRESP[0] ^ M_AXI.RRESP[0];
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_arbiter
// Bench for axil_reg_arbiter: behavioural AXI4-Lite register slave with
// programmable ready delays / response codes, a vector table of directed
// transactions, arbitration and reset sequences, and a randomized phase
// checked against an array-based register model.
// ---------------------------------------------------------------------------
module tb_axil_reg_arbiter;
    localparam int AW = 5;
    localparam int NR = 4;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;

    logic            v_r [2] = '{1'b0, 1'b0};
    logic            we_r[2] = '{1'b0, 1'b0};
    logic [AW-1:0]   a_r [2] = '{'0, '0};
    logic [31:0]     d_r [2] = '{32'd0, 32'd0};
    logic [1:0]      REQ_VALID, REQ_WE, REQ_READY, RSP_VALID;
    logic [2*AW-1:0] REQ_ADDR;
    logic [63:0]     REQ_WDATA;
    logic [31:0]     RSP_RDATA;
    logic            RSP_ERR, BUSY;

    assign REQ_VALID = {v_r[1], v_r[0]};
    assign REQ_WE    = {we_r[1], we_r[0]};
    assign REQ_ADDR  = {a_r[1], a_r[0]};
    assign REQ_WDATA = {d_r[1], d_r[0]};

    axil_reg_arbiter_if #(.ADDR_W(AW)) bus();

    axil_reg_arbiter #(.ADDR_W(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY), .M_AXI(bus)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          ovr_en = 1'b0, r_stall = 1'b0;
    logic [31:0] ovr_data = 32'd0;

    int          aw_wait, w_wait, ar_wait;
    logic        have_aw, have_w, bvalid_s, rvalid_s;
    logic [AW-1:0] aw_addr_q;
    logic [31:0] w_data_q, rdata_s;
    logic [1:0]  bresp_s, rresp_s;
    logic [31:0] slv_mem [NR];

    assign bus.AWREADY = bus.AWVALID && (aw_wait >= aw_delay);
    assign bus.WREADY  = bus.WVALID  && (w_wait  >= w_delay);
    assign bus.ARREADY = bus.ARVALID && (ar_wait >= ar_delay);
    assign bus.BVALID  = bvalid_s;
    assign bus.BRESP   = bresp_s;
    assign bus.RVALID  = rvalid_s;
    assign bus.RDATA   = rdata_s;
    assign bus.RRESP   = rresp_s;

    wire           aw_hs   = bus.AWVALID && bus.AWREADY;
    wire           w_hs    = bus.WVALID && bus.WREADY;
    wire           ar_hs   = bus.ARVALID && bus.ARREADY;
    wire           aw_done = have_aw || aw_hs;
    wire           w_done  = have_w || w_hs;
    wire [AW-1:0]  wr_addr = have_aw ? aw_addr_q : bus.AWADDR;
    wire [31:0]    wr_data = have_w ? w_data_q : bus.WDATA;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            have_aw <= 1'b0; have_w <= 1'b0;
            bvalid_s <= 1'b0; rvalid_s <= 1'b0;
            bresp_s <= 2'b00; rresp_s <= 2'b00; rdata_s <= 32'd0;
            aw_addr_q <= '0; w_data_q <= 32'd0;
        end else begin
            if (aw_hs) aw_wait <= 0; else if (bus.AWVALID) aw_wait <= aw_wait + 1;
            if (w_hs)  w_wait  <= 0; else if (bus.WVALID)  w_wait  <= w_wait + 1;
            if (ar_hs) ar_wait <= 0; else if (bus.ARVALID) ar_wait <= ar_wait + 1;
            if (bvalid_s && bus.BREADY) bvalid_s <= 1'b0;
            if (aw_done && w_done) begin
                have_aw <= 1'b0; have_w <= 1'b0;
                bvalid_s <= 1'b1; bresp_s <= bresp_cfg;
                if (!bresp_cfg[1]) slv_mem[wr_addr[3:2]] <= wr_data;
            end else begin
                if (aw_hs) begin have_aw <= 1'b1; aw_addr_q <= bus.AWADDR; end
                if (w_hs)  begin have_w  <= 1'b1; w_data_q  <= bus.WDATA;  end
            end
            if (rvalid_s && bus.RREADY) rvalid_s <= 1'b0;
            if (ar_hs && !r_stall) begin
                rvalid_s <= 1'b1;
                rdata_s  <= ovr_en ? ovr_data : slv_mem[bus.ARADDR[3:2]];
                rresp_s  <= rresp_cfg;
            end
        end
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    int   cyc = 0;
    int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, rsp_cnt = 0, ovl_cnt = 0;
    int   aw_rise = -1;
    logic aw_prev = 1'b0;

    always @(posedge ACLK) cyc <= cyc + 1;

    always begin
        @(negedge ACLK);
        #2;
        if (bus.AWVALID) aw_cnt = aw_cnt + 1;
        if (bus.WVALID)  w_cnt  = w_cnt + 1;
        if (bus.ARVALID) ar_cnt = ar_cnt + 1;
        if (bus.BVALID && bus.BREADY) b_cnt = b_cnt + 1;
        if (RSP_VALID != 2'b00) rsp_cnt = rsp_cnt + 1;
        if (RSP_VALID != 2'b00 && REQ_READY != 2'b00) ovl_cnt = ovl_cnt + 1;
        if (bus.AWVALID && !aw_prev) aw_rise = cyc;
        aw_prev = bus.AWVALID;
    end

    // ---------------- checking helpers ----------------
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input int r, input bit we, input logic [AW-1:0] a,
                         input logic [31:0] d, output int acc);
        int n = 0;
        @(negedge ACLK);
        v_r[r] = 1'b1; we_r[r] = we; a_r[r] = a; d_r[r] = d;
        #1;
        while (REQ_READY[r] !== 1'b1 && n < 100) begin
            @(negedge ACLK); #1; n++;
        end
        acc = cyc;
        chk($sformatf("accept_r%0d_timeout", r), 32'(n >= 100), 32'd0);
        @(negedge ACLK);
        v_r[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int r, output logic [31:0] d, output logic e, output int c);
        int n = 0;
        #1;
        while (RSP_VALID[r] !== 1'b1 && n < 100) begin
            @(negedge ACLK); #1; n++;
        end
        c = cyc; d = RSP_RDATA; e = RSP_ERR;
        chk($sformatf("rsp_onehot_r%0d", r), 32'(RSP_VALID), 32'd1 << r);
    endtask

    // Register-bank reference: local address check, then array read/write.
    logic [31:0] ref_mem [NR];

    function automatic void ref_apply(input bit we, input logic [AW-1:0] a, input logic [31:0] wd,
                                      input logic [1:0] br, input logic [1:0] rr,
                                      output bit err, output logic [31:0] rd);
        int ai = int'(a);
        rd = 32'd0;
        if ((ai % 4) != 0 || ai >= NR * 4) err = 1'b1;
        else if (we) begin
            err = br[1];
            if (!br[1]) ref_mem[ai / 4] = wd;
        end else begin
            err = rr[1];
            rd  = ref_mem[ai / 4];
        end
    endfunction

    typedef struct {
        int r; bit we; logic [AW-1:0] addr; logic [31:0] wdata;
        int aw_d; int w_d; int ar_d; logic [1:0] bresp; bit ovr; logic [31:0] ovr_d;
        bit exp_err; logic [31:0] exp_rdata; int exp_lat;
        int exp_aw; int exp_w; int exp_ar; int exp_b;
    } vec_t;

    vec_t        vt[9];
    int          acc, rc, s_aw, s_w, s_ar, s_b, s_rsp;
    logic [31:0] rd;
    logic        er;
    bit          m_err;
    logic [31:0] m_rd;
    int          acc0[2], acc1[2], c0[2], c1[2];
    logic [31:0] rd0[2], rd1[2];
    logic        er0[2], er1[2];

    initial begin
        for (int i = 0; i < NR; i++) begin slv_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
        //          r we addr   wdata         awd wd ard bresp ovr ovr_d         err rdata        lat aw w ar b
        vt[0] = '{0, 1, 5'h04, 32'hA5A5_0001, 0, 0, 0, 2'b00, 0, 32'd0,        0, 32'd0,        3, 1, 1, 0, 1};
        vt[1] = '{0, 0, 5'h04, 32'd0,         0, 0, 0, 2'b00, 0, 32'd0,        0, 32'hA5A5_0001, 3, 0, 0, 1, 0};
        vt[2] = '{1, 1, 5'h10, 32'h5555_5555, 0, 0, 0, 2'b00, 0, 32'd0,        1, 32'd0,        1, 0, 0, 0, 0};
        vt[3] = '{1, 0, 5'h06, 32'd0,         0, 0, 0, 2'b00, 0, 32'd0,        1, 32'd0,        1, 0, 0, 0, 0};
        vt[4] = '{0, 1, 5'h08, 32'h1234_5678, 3, 0, 0, 2'b00, 0, 32'd0,        0, 32'd0,       -1, 4, 1, 0, 1};
        vt[5] = '{1, 1, 5'h0C, 32'hFFFF_0000, 0, 0, 0, 2'b10, 0, 32'd0,        1, 32'd0,        3, 1, 1, 0, 1};
        vt[6] = '{0, 0, 5'h00, 32'd0,         0, 0, 0, 2'b00, 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 3, 0, 0, 1, 0};
        vt[7] = '{1, 0, 5'h08, 32'd0,         0, 0, 2, 2'b00, 0, 32'd0,        0, 32'h1234_5678, -1, 0, 0, 3, 0};
        vt[8] = '{1, 0, 5'h0C, 32'd0,         0, 0, 0, 2'b00, 0, 32'd0,        0, 32'd0,        3, 0, 0, 1, 0};

        // reset state
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rsp", {30'd0, RSP_VALID}, 32'd0);
        chk("rst_axi_valids", 32'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}), 32'd0);
        chk("rst_addr_data", bus.WDATA | 32'(bus.AWADDR) | RSP_RDATA, 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK); #1;
        chk("const_strb_prot", 32'({bus.WSTRB, bus.AWPROT, bus.ARPROT}), 32'h3C0);

        // directed vector table
        for (int i = 0; i < 9; i++) begin
            aw_delay = vt[i].aw_d; w_delay = vt[i].w_d; ar_delay = vt[i].ar_d;
            bresp_cfg = vt[i].bresp; rresp_cfg = 2'b00;
            ovr_en = vt[i].ovr; ovr_data = vt[i].ovr_d;
            s_aw = aw_cnt; s_w = w_cnt; s_ar = ar_cnt; s_b = b_cnt; s_rsp = rsp_cnt;
            ref_apply(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].bresp, 2'b00, m_err, m_rd);
            issue(vt[i].r, vt[i].we, vt[i].addr, vt[i].wdata, acc);
            wait_rsp(vt[i].r, rd, er, rc);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
            if (vt[i].exp_lat >= 0) chk($sformatf("v%0d_latency", i), 32'(rc - acc), 32'(vt[i].exp_lat));
            if (vt[i].exp_aw > 0) chk($sformatf("v%0d_aw_at_T1", i), 32'(aw_rise - acc), 32'd1);
            repeat (2) @(negedge ACLK);
            #3;
            chk($sformatf("v%0d_aw_cycles", i), 32'(aw_cnt - s_aw), 32'(vt[i].exp_aw));
            chk($sformatf("v%0d_w_cycles", i), 32'(w_cnt - s_w), 32'(vt[i].exp_w));
            chk($sformatf("v%0d_ar_cycles", i), 32'(ar_cnt - s_ar), 32'(vt[i].exp_ar));
            chk($sformatf("v%0d_b_count", i), 32'(b_cnt - s_b), 32'(vt[i].exp_b));
            chk($sformatf("v%0d_rsp_count", i), 32'(rsp_cnt - s_rsp), 32'd1);
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0; bresp_cfg = 2'b00; ovr_en = 1'b0;

        // round-robin: seed registers, reset (last=1), then both requesters stream reads
        ref_apply(1'b1, 5'h00, 32'h1111_0000, 2'b00, 2'b00, m_err, m_rd);
        issue(0, 1'b1, 5'h00, 32'h1111_0000, acc); wait_rsp(0, rd, er, rc);
        ref_apply(1'b1, 5'h08, 32'h2222_8888, 2'b00, 2'b00, m_err, m_rd);
        issue(1, 1'b1, 5'h08, 32'h2222_8888, acc); wait_rsp(1, rd, er, rc);
        @(negedge ACLK); ARESET = 1'b1; @(negedge ACLK); ARESET = 1'b0;
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    issue(0, 1'b0, 5'h00, 32'd0, acc0[k]); wait_rsp(0, rd0[k], er0[k], c0[k]);
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    issue(1, 1'b0, 5'h08, 32'd0, acc1[k]); wait_rsp(1, rd1[k], er1[k], c1[k]);
                end
            end
        join
        chk("rr_order_0_1", 32'(acc0[0] < acc1[0]), 32'd1);
        chk("rr_order_1_0", 32'(acc1[0] < acc0[1]), 32'd1);
        chk("rr_order_0_1b", 32'(acc0[1] < acc1[1]), 32'd1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rr_r0_data%0d", k), rd0[k], ref_mem[0]);
            chk($sformatf("rr_r1_data%0d", k), rd1[k], ref_mem[2]);
            chk($sformatf("rr_err%0d", k), 32'({er0[k], er1[k]}), 32'd0);
        end

        // reset while waiting on RVALID
        r_stall = 1'b1;
        issue(0, 1'b0, 5'h04, 32'd0, acc);
        repeat (3) @(negedge ACLK);
        #1;
        chk("rdwait_rready", 32'({bus.RREADY, BUSY}), 32'h3);
        s_rsp = rsp_cnt;
        ARESET = 1'b1;
        #1;
        chk("midrst_axi_low", 32'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0; r_stall = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("midrst_no_rsp", 32'(rsp_cnt - s_rsp), 32'd0);
        fork
            begin issue(0, 1'b0, 5'h04, 32'd0, acc0[0]); wait_rsp(0, rd0[0], er0[0], c0[0]); end
            begin issue(1, 1'b0, 5'h08, 32'd0, acc1[0]); wait_rsp(1, rd1[0], er1[0], c1[0]); end
        join
        chk("postrst_r0_first", 32'(acc0[0] < acc1[0]), 32'd1);
        chk("postrst_r0_data", rd0[0], ref_mem[1]);
        chk("postrst_r1_data", rd1[0], ref_mem[2]);

        // randomized traffic vs. register model
        for (int i = 0; i < 30; i++) begin
            int          r;
            bit          we;
            logic [AW-1:0] a;
            logic [31:0] d;
            r  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = AW'($urandom_range(0, 31));
            else a = AW'($urandom_range(0, 3) * 4);
            d = $urandom;
            aw_delay = int'($urandom_range(0, 3));
            w_delay  = int'($urandom_range(0, 3));
            ar_delay = int'($urandom_range(0, 3));
            bresp_cfg = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
            ref_apply(we, a, d, bresp_cfg, 2'b00, m_err, m_rd);
            issue(r, we, a, d, acc);
            wait_rsp(r, rd, er, rc);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(m_err));
            chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
        end

        repeat (2) @(negedge ACLK);
        chk("ready_rsp_overlap", 32'(ovl_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
